// File: rtl/chip8_timers.sv
// CHIP-8 style countdown timers (delay/sound) driven by a shared prescaler.
// Optional macro CHIP8_TIMER_EXPIRE_EN adds the expire_out pulse port.
module chip8_timers #(
    parameter int  NUM_TIMERS = 2,
    parameter int  WIDTH      = 8,
    parameter int  CLK_HZ     = 100_000_000,
    parameter int  TICK_HZ    = 60,
    localparam int SELW       = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  en_in,
    input  logic                  wr_en_in,
    input  logic [SELW-1:0]       wr_sel_in,
    input  logic [WIDTH-1:0]      wr_data_in,
    input  logic [SELW-1:0]       rd_sel_in,
    output logic [WIDTH-1:0]      rd_data_out,
    output logic [NUM_TIMERS-1:0] active_out,
    output logic                  tick_out
`ifdef CHIP8_TIMER_EXPIRE_EN
    ,
    output logic [NUM_TIMERS-1:0] expire_out
`endif
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0]    cnt;
    logic             tick;
    logic [WIDTH-1:0] tmr [NUM_TIMERS];
    logic [WIDTH-1:0] rd_mux;
    logic [NUM_TIMERS-1:0] load_hit;

    assign tick = en_in && (cnt == LAST);

    // Decode which timer (if any) the load strobe targets
    always_comb begin
        load_hit = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            load_hit[i] = wr_en_in && (wr_sel_in == SELW'(i));
        end
    end

    // Prescaler: counts only while enabled, freezes otherwise
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (en_in) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

    // Timer registers: load beats tick, zero saturates
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                tmr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (load_hit[i]) begin
                    tmr[i] <= wr_data_in;
                end else if (tick && (tmr[i] != '0)) begin
                    tmr[i] <= tmr[i] - WIDTH'(1);
                end
            end
        end
    end

    // Readback select; out-of-range index reads as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (rd_sel_in == SELW'(i)) begin
                rd_mux = tmr[i];
            end
        end
    end

    // Registered readback and tick pulse
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_data_out <= '0;
            tick_out    <= 1'b0;
        end else begin
            rd_data_out <= rd_mux;
            tick_out    <= tick;
        end
    end

    // Nonzero flags straight from the timer registers
    always_comb begin
        active_out = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            active_out[i] = (tmr[i] != '0);
        end
    end

`ifdef CHIP8_TIMER_EXPIRE_EN
    // Expiry pulse only for a tick-driven 1->0 step not overridden by a load
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            expire_out <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                expire_out[i] <= tick && !load_hit[i]
                                 && (tmr[i] == WIDTH'(1));
            end
        end
    end
`endif

endmodule

// File: tb/tb_chip8_timers.sv
// Directed bench for chip8_timers with DIV=10 (CLK_HZ=600, TICK_HZ=60).
// Build with +define+CHIP8_TIMER_EXPIRE_EN to also cover expire_out.
module tb_chip8_timers;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic       en_in = 1'b0;
    logic       wr_en_in = 1'b0;
    logic [0:0] wr_sel_in = '0;
    logic [7:0] wr_data_in = '0;
    logic [0:0] rd_sel_in = '0;
    logic [7:0] rd_data_out;
    logic [1:0] active_out;
    logic       tick_out;

    logic       en1 = 1'b0;
    logic       wr_en1 = 1'b0;
    logic [0:0] wr_sel1 = '0;
    logic [7:0] wr_data1 = '0;
    logic [0:0] rd_sel1 = '0;
    logic [7:0] rd_data1;
    logic [0:0] active1;
    logic       tick1;

`ifdef CHIP8_TIMER_EXPIRE_EN
    logic [1:0] expire_out;
    logic [0:0] expire1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chip8_timers #(
        .NUM_TIMERS(2), .WIDTH(8), .CLK_HZ(600), .TICK_HZ(60)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .en_in(en_in),
        .wr_en_in(wr_en_in), .wr_sel_in(wr_sel_in),
        .wr_data_in(wr_data_in), .rd_sel_in(rd_sel_in),
        .rd_data_out(rd_data_out), .active_out(active_out),
        .tick_out(tick_out)
`ifdef CHIP8_TIMER_EXPIRE_EN
        , .expire_out(expire_out)
`endif
    );

    chip8_timers #(
        .NUM_TIMERS(1), .WIDTH(8), .CLK_HZ(600), .TICK_HZ(60)
    ) dut1 (
        .clk_in(clk), .rst_in(rst_in), .en_in(en1),
        .wr_en_in(wr_en1), .wr_sel_in(wr_sel1),
        .wr_data_in(wr_data1), .rd_sel_in(rd_sel1),
        .rd_data_out(rd_data1), .active_out(active1),
        .tick_out(tick1)
`ifdef CHIP8_TIMER_EXPIRE_EN
        , .expire_out(expire1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_out && n < 40);
        chk(tag, n, exp);
    endtask

    task automatic load(input logic [0:0] sel, input logic [7:0] d);
        wr_en_in   = 1'b1;
        wr_sel_in  = sel;
        wr_data_in = d;
        step();
        wr_en_in   = 1'b0;
    endtask

    initial begin
        int seen;

        step(2);
        chk("rst_tick", tick_out, 0);
        chk("rst_active", active_out, 0);
        chk("rst_rd", rd_data_out, 0);
        rst_in = 1'b0;

        // countdown on channel 1
        load(1'b1, 8'd3);
        chk("cd_active_load", active_out, 2'b10);
        rd_sel_in = 1'b1;
        en_in = 1'b1;
        wait_tick("cd_tick1_lat", 10);
        chk("cd_active_t1", active_out, 2'b10);
        step();
        chk("cd_rd_2", rd_data_out, 2);
        wait_tick("cd_tick2_lat", 9);
        step();
        chk("cd_rd_1", rd_data_out, 1);
        wait_tick("cd_tick3_lat", 9);
        chk("cd_active_0", active_out, 2'b00);
        step();
        chk("cd_rd_0", rd_data_out, 0);
        wait_tick("cd_tick4_lat", 9);
        step();
        chk("cd_rd_stay0", rd_data_out, 0);
        chk("cd_active_stay", active_out, 2'b00);

        // collision: load ch0 in the tick cycle (prescaler now at 1)
        step(8);
        rd_sel_in  = 1'b0;
        load(1'b0, 8'd5);
        chk("col_tick", tick_out, 1);
        step();
        chk("col_rd_5", rd_data_out, 5);
        wait_tick("col_tick_lat", 9);
        step();
        chk("col_rd_4", rd_data_out, 4);

        // pause at prescaler count 4
        step(3);
        en_in = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (tick_out) seen++;
        end
        chk("pause_no_tick", seen, 0);
        chk("pause_rd_hold", rd_data_out, 4);
        en_in = 1'b1;
        wait_tick("pause_resume_lat", 6);
        step();
        chk("pause_rd_3", rd_data_out, 3);

        // reset mid-run with prescaler at 7 and a competing load
        load(1'b0, 8'd200);
        step(5);
        chk("mr_rd_200", rd_data_out, 200);
        rst_in     = 1'b1;
        wr_en_in   = 1'b1;
        wr_sel_in  = 1'b1;
        wr_data_in = 8'd77;
        step();
        rst_in   = 1'b0;
        wr_en_in = 1'b0;
        chk("mr_active", active_out, 0);
        chk("mr_tick", tick_out, 0);
        chk("mr_rd", rd_data_out, 0);
        wait_tick("mr_tick_lat", 10);
        chk("mr_active_tick", active_out, 0);

`ifdef CHIP8_TIMER_EXPIRE_EN
        // expiry pulse on 1->0, none on load of 0
        load(1'b1, 8'd1);
        chk("exp_idle", expire_out, 0);
        wait_tick("exp_tick_lat", 9);
        chk("exp_pulse", expire_out, 2'b10);
        step();
        chk("exp_one_cycle", expire_out, 0);
        load(1'b1, 8'd0);
        chk("exp_load0_a", expire_out, 0);
        step();
        chk("exp_load0_b", expire_out, 0);
`endif

        // single-timer instance: illegal index ignored, reads as zero
        wr_en1   = 1'b1;
        wr_sel1  = 1'b0;
        wr_data1 = 8'd9;
        step();
        wr_sel1  = 1'b1;
        wr_data1 = 8'd55;
        step();
        wr_en1   = 1'b0;
        chk("ill_active", active1, 1);
        rd_sel1 = 1'b0;
        step();
        chk("ill_rd_9", rd_data1, 9);
        rd_sel1 = 1'b1;
        step();
        chk("ill_rd_oob", rd_data1, 0);
        chk("ill_no_tick", tick1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
